// File: rtl/ps2_scan_fifo_if.sv
// Head-of-FIFO handshake between the PS/2 scan-code buffer and its consumer.
interface ps2_scan_fifo_if #(
  parameter int DATA_W = 8
);
  logic              Pop;
  logic              Valid;
  logic [DATA_W-1:0] Code;
  logic              Ext;
  logic              Brk;
  logic              Full;

  modport master (input Pop, output Valid, output Code, output Ext, output Brk, output Full);
  modport slave  (output Pop, input Valid, input Code, input Ext, input Brk, input Full);
endinterface

// File: rtl/ps2_scan_fifo.sv
// PS/2 keyboard receive path: line synchroniser, frame receiver with parity,
// stop and timeout checks, E0/F0 prefix folding and a first-word-fall-through FIFO.
module ps2_scan_fifo #(
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 2000,
  parameter int EN_PREFIX   = 1
) (
  input  logic Clk,
  input  logic Reset,
  input  logic KbClk,
  input  logic KbData,
  ps2_scan_fifo_if.master fifo,
  output logic Busy,
  output logic ParityErr,
  output logic FrameErr,
  output logic OvfErr
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int BC_W  = $clog2(DATA_W + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int WW    = DATA_W + 2;
  localparam bit PFX_OK = (EN_PREFIX != 0) && (DATA_W == 8);
  localparam logic [DATA_W-1:0] CODE_E0 = DATA_W'(8'hE0);
  localparam logic [DATA_W-1:0] CODE_F0 = DATA_W'(8'hF0);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic kclk_p0, kclk_p1, kclk_p2;
  logic kdat_p0, kdat_p1;
  logic fall, bit_in;

  state_t state, state_n;
  logic [BC_W-1:0] bitcnt, bitcnt_n;
  logic [TO_W-1:0] tocnt;
  logic [DATA_W-1:0] shreg;
  logic par_bit, par_ok, timeout;
  logic perr_n, ferr_n, byte_ok;
  logic perr_q, ferr_q, ovf_q;
  logic is_e0, is_f0, push_req;
  logic pend_ext, pend_brk, pend_ext_n, pend_brk_n;

  logic [WW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic do_push, do_pop, ovf_n;
  logic [WW-1:0] head;

  // Stage p0..p2: two-flop synchroniser on both lines plus a third KbClk flop for edge detect
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      kclk_p0 <= 1'b1;
      kclk_p1 <= 1'b1;
      kclk_p2 <= 1'b1;
      kdat_p0 <= 1'b1;
      kdat_p1 <= 1'b1;
    end else begin
      kclk_p0 <= KbClk;
      kclk_p1 <= kclk_p0;
      kclk_p2 <= kclk_p1;
      kdat_p0 <= KbData;
      kdat_p1 <= kdat_p0;
    end
  end

  assign fall   = ~kclk_p1 & kclk_p2;
  assign bit_in = kdat_p1;
  assign par_ok = ^{shreg, par_bit};
  // tocnt holds k on the k-th cycle after the clearing edge, so T-1 means T cycles have elapsed
  assign timeout = (state != IDLE) && (tocnt == TO_W'(TIMEOUT_CYC - 1));

  // Receiver next-state: frame sequencing and stop/parity/timeout verdicts
  always_comb begin
    state_n  = state;
    bitcnt_n = bitcnt;
    perr_n   = 1'b0;
    ferr_n   = 1'b0;
    byte_ok  = 1'b0;
    if (timeout) begin
      state_n = IDLE;
      ferr_n  = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE: begin
          if (!bit_in) begin
            state_n  = DATA;
            bitcnt_n = '0;
          end else begin
            ferr_n = 1'b1;
          end
        end
        DATA: begin
          bitcnt_n = bitcnt + BC_W'(1);
          if (bitcnt == BC_W'(DATA_W - 1)) state_n = PARITY;
        end
        PARITY: state_n = STOP;
        STOP: begin
          state_n = IDLE;
          if (!bit_in)      ferr_n  = 1'b1;
          else if (!par_ok) perr_n  = 1'b1;
          else              byte_ok = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Prefix folding and FIFO push/pop decisions
  always_comb begin
    is_e0      = PFX_OK && (shreg == CODE_E0);
    is_f0      = PFX_OK && (shreg == CODE_F0);
    push_req   = byte_ok && !is_e0 && !is_f0;
    pend_ext_n = pend_ext;
    pend_brk_n = pend_brk;
    if (perr_n || ferr_n) begin
      pend_ext_n = 1'b0;
      pend_brk_n = 1'b0;
    end else if (byte_ok) begin
      if (is_e0) begin
        pend_ext_n = 1'b1;
      end else if (is_f0) begin
        pend_brk_n = 1'b1;
      end else begin
        pend_ext_n = 1'b0;
        pend_brk_n = 1'b0;
      end
    end
    do_pop  = fifo.Pop && (count != '0);
    do_push = push_req && ((count != CNT_W'(FIFO_DEPTH)) || do_pop);
    ovf_n   = push_req && !do_push;
  end

  // Control state: FSM, counters, pending flags, FIFO pointers and registered error pulses
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      bitcnt   <= '0;
      tocnt    <= '0;
      pend_ext <= 1'b0;
      pend_brk <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state    <= state_n;
      bitcnt   <= bitcnt_n;
      tocnt    <= (fall || state == IDLE) ? '0 : tocnt + TO_W'(1);
      pend_ext <= pend_ext_n;
      pend_brk <= pend_brk_n;
      perr_q   <= perr_n;
      ferr_q   <= ferr_n;
      ovf_q    <= ovf_n;
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Datapath: shift register, parity latch and FIFO storage carry no reset
  always_ff @(posedge Clk) begin
    if (fall && state == DATA)   shreg   <= {bit_in, shreg[DATA_W-1:1]};
    if (fall && state == PARITY) par_bit <= bit_in;
    if (do_push)                 mem[wr_ptr] <= {pend_ext, pend_brk, shreg};
  end

  assign head       = mem[rd_ptr];
  assign fifo.Valid = (count != '0);
  assign fifo.Full  = (count == CNT_W'(FIFO_DEPTH));
  assign fifo.Code  = fifo.Valid ? head[DATA_W-1:0] : '0;
  assign fifo.Brk   = fifo.Valid & head[DATA_W];
  assign fifo.Ext   = fifo.Valid & head[DATA_W+1];
  assign Busy       = (state != IDLE);
  assign ParityErr  = perr_q;
  assign FrameErr   = ferr_q;
  assign OvfErr     = ovf_q;
endmodule

// File: tb/tb_ps2_scan_fifo.sv
// Directed bench for ps2_scan_fifo: frames, prefixes, errors, overflow, timeout, reset.
module tb_ps2_scan_fifo;
  localparam int TO = 60;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  logic KbClk = 1'b1;
  logic KbData = 1'b1;
  logic Busy, ParityErr, FrameErr, OvfErr;

  int n_cmp = 0;
  int n_bad = 0;
  int perr_cnt = 0;
  int ferr_cnt = 0;
  int ovf_cnt = 0;

  ps2_scan_fifo_if #(.DATA_W(8)) bus ();

  ps2_scan_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .TIMEOUT_CYC(TO), .EN_PREFIX(1)) dut (
    .Clk(Clk), .Reset(Reset), .KbClk(KbClk), .KbData(KbData), .fifo(bus),
    .Busy(Busy), .ParityErr(ParityErr), .FrameErr(FrameErr), .OvfErr(OvfErr)
  );

  always #5 Clk = ~Clk;

  // count high cycles of each pulse so a stretched pulse counts more than once
  always @(negedge Clk) begin
    if (ParityErr) perr_cnt <= perr_cnt + 1;
    if (FrameErr)  ferr_cnt <= ferr_cnt + 1;
    if (OvfErr)    ovf_cnt  <= ovf_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic kb_bit(input logic b);
    KbData = b;
    tick(4);
    KbClk = 1'b0;
    tick(8);
    KbClk = 1'b1;
    tick(8);
  endtask

  task automatic send_frame(input logic [7:0] code, input logic par_flip, input logic stop);
    kb_bit(1'b0);
    for (int i = 0; i < 8; i++) kb_bit(code[i]);
    kb_bit((~^code) ^ par_flip);
    kb_bit(stop);
    KbData = 1'b1;
    tick(2);
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] code, input logic ext, input logic brk);
    chk({tag, ".valid"}, 32'(bus.Valid), 32'd1);
    chk({tag, ".code"},  32'(bus.Code),  32'(code));
    chk({tag, ".ext"},   32'(bus.Ext),   32'(ext));
    chk({tag, ".brk"},   32'(bus.Brk),   32'(brk));
    bus.Pop = 1'b1;
    tick(1);
    bus.Pop = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".valid"}, 32'(bus.Valid), 32'd0);
    chk({tag, ".full"},  32'(bus.Full),  32'd0);
    chk({tag, ".busy"},  32'(Busy),      32'd0);
    chk({tag, ".code"},  32'(bus.Code),  32'd0);
    chk({tag, ".ext"},   32'(bus.Ext),   32'd0);
    chk({tag, ".brk"},   32'(bus.Brk),   32'd0);
    chk({tag, ".errs"},  32'({ParityErr, FrameErr, OvfErr}), 32'd0);
  endtask

  initial begin
    int p0, f0, o0, first, busy_at, late;
    logic [7:0] burst [5];
    burst[0] = 8'h16; burst[1] = 8'h1E; burst[2] = 8'h26; burst[3] = 8'h25; burst[4] = 8'h2E;
    bus.Pop = 1'b0;

    tick(3);
    chk_reset_outputs("rst");
    Reset = 1'b1;
    tick(3);

    // plain make code
    p0 = perr_cnt; f0 = ferr_cnt; o0 = ovf_cnt;
    send_frame(8'h1C, 1'b0, 1'b1);
    pop_chk("plain", 8'h1C, 1'b0, 1'b0);
    chk("plain.empty", 32'(bus.Valid), 32'd0);
    chk("plain.errs", 32'(perr_cnt - p0 + ferr_cnt - f0 + ovf_cnt - o0), 32'd0);

    // break and extended-break prefixes
    send_frame(8'hF0, 1'b0, 1'b1);
    chk("brk.pfx_not_pushed", 32'(bus.Valid), 32'd0);
    send_frame(8'h1C, 1'b0, 1'b1);
    pop_chk("brk", 8'h1C, 1'b0, 1'b1);
    chk("brk.single", 32'(bus.Valid), 32'd0);
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    pop_chk("extbrk", 8'h75, 1'b1, 1'b1);
    chk("extbrk.single", 32'(bus.Valid), 32'd0);

    // parity error clears a pending break
    p0 = perr_cnt; f0 = ferr_cnt;
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b1, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("perr.count", 32'(perr_cnt - p0), 32'd1);
    chk("perr.ferr", 32'(ferr_cnt - f0), 32'd0);
    pop_chk("perr", 8'h1C, 1'b0, 1'b0);
    chk("perr.single", 32'(bus.Valid), 32'd0);

    // bad stop bit with bad parity only reports a frame error
    p0 = perr_cnt; f0 = ferr_cnt;
    send_frame(8'h1C, 1'b1, 1'b0);
    chk("stop.ferr", 32'(ferr_cnt - f0), 32'd1);
    chk("stop.perr", 32'(perr_cnt - p0), 32'd0);
    chk("stop.nopush", 32'(bus.Valid), 32'd0);

    // fill, overflow, drain
    o0 = ovf_cnt;
    for (int i = 0; i < 5; i++) begin
      send_frame(burst[i], 1'b0, 1'b1);
      if (i == 2) chk("fill.not_full3", 32'(bus.Full), 32'd0);
      if (i == 3) chk("fill.full4", 32'(bus.Full), 32'd1);
      if (i == 3) chk("fill.no_ovf4", 32'(ovf_cnt - o0), 32'd0);
    end
    chk("fill.ovf", 32'(ovf_cnt - o0), 32'd1);
    chk("fill.still_full", 32'(bus.Full), 32'd1);
    for (int i = 0; i < 4; i++) begin
      pop_chk("drain", burst[i], 1'b0, 1'b0);
      if (i == 0) chk("drain.full_drop", 32'(bus.Full), 32'd0);
    end
    chk("drain.empty", 32'(bus.Valid), 32'd0);
    bus.Pop = 1'b1;
    tick(1);
    bus.Pop = 1'b0;
    chk("drain.pop_empty", 32'(bus.Valid), 32'd0);

    // timeout after start plus three data bits
    f0 = ferr_cnt;
    kb_bit(1'b0);
    chk("to.busy", 32'(Busy), 32'd1);
    kb_bit(1'b1);
    kb_bit(1'b0);
    KbData = 1'b1;
    tick(4);
    KbClk = 1'b0;
    first = -1;
    busy_at = 1;
    late = 0;
    for (int n = 1; n <= TO + 6; n++) begin
      @(posedge Clk);
      #1;
      if (n == 8) KbClk = 1'b1;
      if (FrameErr && first < 0) begin
        first = n;
        busy_at = int'(Busy);
      end else if (FrameErr) begin
        late = late + 1;
      end
    end
    chk("to.when", 32'(first), 32'(TO + 3));
    chk("to.busy_off", 32'(busy_at), 32'd0);
    chk("to.width", 32'(late), 32'd0);
    chk("to.count", 32'(ferr_cnt - f0), 32'd1);
    chk("to.nopush", 32'(bus.Valid), 32'd0);
    send_frame(8'h1C, 1'b0, 1'b1);
    pop_chk("to.after", 8'h1C, 1'b0, 1'b0);

    // reset mid-frame
    kb_bit(1'b0);
    for (int i = 0; i < 5; i++) kb_bit(i[0]);
    Reset = 1'b0;
    KbData = 1'b1;
    tick(2);
    chk_reset_outputs("midrst");
    Reset = 1'b1;
    tick(3);
    chk("midrst.idle", 32'(bus.Valid), 32'd0);
    send_frame(8'h1C, 1'b0, 1'b1);
    pop_chk("midrst.after", 8'h1C, 1'b0, 1'b0);
    chk("midrst.single", 32'(bus.Valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ps2_scan_fifo.md
# ps2_scan_fifo

Parametrised PS/2 keyboard receive path, replacing the fixed load/new/clear scan-code controller. It synchronises the raw keyboard clock and data lines and assembles framed bytes, with parity and stop checks and a frame timeout. It folds the E0 (extended) and F0 (break) prefixes into flags on the following code and buffers the completed codes in a first-word-fall-through FIFO for the downstream consumer.

## Interface
- DATA_W, 8: data bits per frame; prefix decoding is only legal when DATA_W = 8
- FIFO_DEPTH, 4: FIFO entries; must be a power of 2 and ≥ 2
- TIMEOUT_CYC, 2000: Clk cycles allowed without a KbClk falling edge before an in-progress frame is aborted
- EN_PREFIX, 1: 1 = fold E0/F0 into flags; 0 = push every byte with Ext = Brk = 0
- Clk  in  1  system clock; all logic is on the rising edge
- Reset  in  1  asynchronous, active-low reset (asserted at 0)
- KbClk  in  1  raw PS/2 clock line, asynchronous
- KbData  in  1  raw PS/2 data line, asynchronous
- Pop  in  1  consumer takes the head word this cycle; ignored when Valid = 0
- Valid  out  1  FIFO not empty; Code/Ext/Brk hold the head word
- Code  out  DATA_W  head scan code
- Ext  out  1  head code was preceded by E0
- Brk  out  1  head code was preceded by F0
- Full  out  1  FIFO holds FIFO_DEPTH words
- Busy  out  1  a frame is in progress (receiver state ≠ IDLE)
- ParityErr  out  1  one-cycle pulse: bad parity
- FrameErr  out  1  one-cycle pulse: bad start bit, bad stop bit or timeout
- OvfErr  out  1  one-cycle pulse: completed word dropped because the FIFO was full

## Operation
- Synchroniser
  - KbClk and KbData each pass through 2 flops, plus a third flop on KbClk.
  - All of these flops reset to 1, so no edge is seen out of reset.
  - A falling edge is detected when the second KbClk flop = 0 and the third = 1.
  - The bit is sampled from the second KbData flop in that same cycle.
- Receiver FSM: IDLE, DATA, PARITY, STOP.
  - IDLE: on an edge with bit = 0, go to DATA and clear the bit counter. An edge with bit = 1 pulses FrameErr and stays in IDLE.
  - DATA: shift bits LSB first. After DATA_W bits, go to PARITY.
  - PARITY: latch the parity bit. Odd parity is required: ones(data) + parity must be odd. Go to STOP.
  - STOP: on an edge, always return to IDLE.
    - Stop bit = 0: pulse FrameErr.
    - Else parity bad: pulse ParityErr.
    - Else the byte is complete.
    - If parity and stop are both bad, only FrameErr pulses.
- Timeout
  - A counter clears on every falling edge and while in IDLE.
  - When it reaches TIMEOUT_CYC in a non-IDLE state, the FSM returns to IDLE and FrameErr pulses.
- Prefix handling (EN_PREFIX = 1)
  - A completed byte E0 sets the pending-Ext flag; F0 sets the pending-Brk flag. Neither is pushed.
  - Any other completed byte is pushed as {pending-Ext, pending-Brk, byte}, and both pending flags then clear.
  - Any ParityErr, FrameErr or timeout clears both pending flags.
- FIFO
  - Push happens on the STOP-edge cycle of a completed non-prefix byte.
  - A push while Full with no Pop drops the word and pulses OvfErr.
  - Push and Pop in the same cycle while Full are both accepted.
  - Pop while empty is ignored.
  - The occupancy counter is $clog2(FIFO_DEPTH)+1 bits wide; the read and write pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: Valid = Full = Busy = Ext = Brk = 0, Code = 0, all error pulses = 0, FSM = IDLE, pending flags = 0, FIFO empty.
- Reset asserted mid-frame: the partial byte is discarded and nothing is pushed.
- Bit sample latency: 3 Clk cycles from a KbClk pad fall to the detect cycle.
- Push cycle N gives Valid = 1 and the head word on cycle N+1.
- Pop at the rising edge of cycle N: the next word (or Valid = 0) is visible on cycle N+1. Full deasserts the same cycle.
- Error pulses are registered and asserted on the cycle after the detect cycle, for exactly 1 cycle.

## Test plan
- Frame 0x1C, parity 0, stop 1 → one push; Code = 0x1C, Ext = 0, Brk = 0; no error pulses.
- Frames F0, 1C → one word only: Code = 0x1C, Brk = 1, Ext = 0. Frames E0, F0, 75 → Code = 0x75, Ext = 1, Brk = 1.
- Frame F0, then 0x1C with parity 1, then 0x1C valid → ParityErr pulses once; a single word 0x1C is pushed with Brk = 0 (pending flag cleared).
- FIFO_DEPTH = 4, five frames 0x16, 0x1E, 0x26, 0x25, 0x2E with no Pop → Full after the 4th and OvfErr on the 5th. Popping then yields 16, 1E, 26, 25 in order; Valid = 0 after the 4th pop.
- Start bit plus 3 data bits, then KbClk held high → FrameErr exactly TIMEOUT_CYC cycles after the last edge and Busy = 0. A following frame 0x1C is received correctly.
- Reset asserted after 5 data bits, released, then frame 0x1C → all outputs at reset values during reset; only 0x1C is pushed afterwards.
